// File: rtl/sweep_counter.sv
// sweep_counter: paces servo steps with a prescaler, counts sweep steps per
// axis, tracks the step index of peak light and the distance back to it.
module sweep_counter #(
  parameter int STEP_DIV = 100000,
  parameter int H_STEPS  = 180,
  parameter int V_STEPS  = 90,
  parameter int ADC_W    = 12,
  parameter int CNT_W    = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             HS,
  input  logic             VS,
  input  logic             MC,
  input  logic             CNT_RST,
  input  logic [ADC_W-1:0] ADC_VAL,
  input  logic             ADC_VALID,
  output logic             CNT_L,
  output logic             CNT_RU,
  output logic             CNT_D,
  output logic [CNT_W-1:0] H_MAX_POS,
  output logic [CNT_W-1:0] V_MAX_POS,
  output logic [ADC_W-1:0] MAX_VAL
);

  localparam int               PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_STEPS);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_STEPS);

  logic [ADC_W-1:0] r_sample;
  logic [PRE_W-1:0] r_pre;
  logic [2:0]       r_en_prev;
  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic [ADC_W-1:0] r_h_max_val;
  logic [ADC_W-1:0] r_v_max_val;
  logic [CNT_W-1:0] r_h_max_pos;
  logic [CNT_W-1:0] r_v_max_pos;
  logic [CNT_W-1:0] r_ret_rem;
  logic             r_axis;

  logic [2:0]       w_en;
  logic             w_any;
  logic             w_change;
  logic             w_hs;
  logic             w_vs;
  logic             w_mc;
  logic             w_tick;
  logic [CNT_W-1:0] w_h_ret;
  logic [CNT_W-1:0] w_v_ret;

  // HS outranks VS, and either sweep outranks the return phase.
  assign w_en     = {HS, VS, MC};
  assign w_any    = |w_en;
  assign w_change = (w_en != r_en_prev);
  assign w_hs     = HS;
  assign w_vs     = VS & ~HS;
  assign w_mc     = MC & ~HS & ~VS;
  // A phase change restarts the step period, so a stale count cannot tick.
  assign w_tick   = w_any & ~w_change & (r_pre == PRE_LAST);
  assign w_h_ret  = r_h_cnt - r_h_max_pos;
  assign w_v_ret  = r_v_cnt - r_v_max_pos;

  // Latch the newest sensor sample; only a full reset clears it.
  always_ff @(posedge CLK) begin
    if (RST)            r_sample <= '0;
    else if (ADC_VALID) r_sample <= ADC_VAL;
  end

  // Remember last cycle's enables to detect phase changes.
  always_ff @(posedge CLK) begin
    if (RST) r_en_prev <= '0;
    else     r_en_prev <= w_en;
  end

  // Step prescaler: free-runs 0..STEP_DIV-1 while a phase is active.
  always_ff @(posedge CLK) begin
    if (RST || CNT_RST || !w_any || w_change) r_pre <= '0;
    else if (r_pre == PRE_LAST)               r_pre <= '0;
    else                                      r_pre <= r_pre + PRE_W'(1);
  end

  // Sweep counters, peak tracking and return distance.
  always_ff @(posedge CLK) begin
    if (RST || CNT_RST) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_h_max_val <= '0;
      r_v_max_val <= '0;
      r_h_max_pos <= '0;
      r_v_max_pos <= '0;
      r_ret_rem   <= '0;
      r_axis      <= 1'b0;
    end else begin
      if (w_hs) begin
        r_axis <= 1'b0;
        if (w_tick && (r_h_cnt < H_LAST)) begin
          // Strict compare keeps the earliest step on ties.
          if ((r_h_cnt == '0) || (r_sample > r_h_max_val)) begin
            r_h_max_val <= r_sample;
            r_h_max_pos <= r_h_cnt;
          end
          r_h_cnt <= r_h_cnt + CNT_W'(1);
        end
      end else if (w_vs) begin
        r_axis <= 1'b1;
        if (w_tick && (r_v_cnt < V_LAST)) begin
          if ((r_v_cnt == '0) || (r_sample > r_v_max_val)) begin
            r_v_max_val <= r_sample;
            r_v_max_pos <= r_v_cnt;
          end
          r_v_cnt <= r_v_cnt + CNT_W'(1);
        end
      end

      // Outside the return phase keep the distance current so it is valid
      // on the very first return cycle.
      if (w_mc) begin
        if (w_tick && (r_ret_rem != '0)) r_ret_rem <= r_ret_rem - CNT_W'(1);
      end else begin
        r_ret_rem <= r_axis ? w_v_ret : w_h_ret;
      end
    end
  end

  assign CNT_L     = (r_h_cnt != H_LAST);
  assign CNT_D     = (r_v_cnt != V_LAST);
  assign CNT_RU    = (r_ret_rem != '0);
  assign H_MAX_POS = r_h_max_pos;
  assign V_MAX_POS = r_v_max_pos;
  assign MAX_VAL   = r_axis ? r_v_max_val : r_h_max_val;

endmodule

// File: tb/tb_sweep_counter.sv
// tb_sweep_counter: directed and randomized sweeps checked against a
// step-level model of peak position, sweep length and return distance.
module tb_sweep_counter;

  localparam int STEP_DIV = 4;
  localparam int H_STEPS  = 8;
  localparam int V_STEPS  = 4;
  localparam int ADC_W    = 12;
  localparam int CNT_W    = 8;

  logic             CLK = 1'b0;
  logic             RST;
  logic             HS;
  logic             VS;
  logic             MC;
  logic             CNT_RST;
  logic [ADC_W-1:0] ADC_VAL;
  logic             ADC_VALID;
  logic             CNT_L;
  logic             CNT_RU;
  logic             CNT_D;
  logic [CNT_W-1:0] H_MAX_POS;
  logic [CNT_W-1:0] V_MAX_POS;
  logic [ADC_W-1:0] MAX_VAL;

  int checks = 0;
  int errors = 0;
  int samp [16];
  int h_keep;

  sweep_counter #(
    .STEP_DIV(STEP_DIV), .H_STEPS(H_STEPS), .V_STEPS(V_STEPS),
    .ADC_W(ADC_W), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .HS(HS), .VS(VS), .MC(MC), .CNT_RST(CNT_RST),
    .ADC_VAL(ADC_VAL), .ADC_VALID(ADC_VALID),
    .CNT_L(CNT_L), .CNT_RU(CNT_RU), .CNT_D(CNT_D),
    .H_MAX_POS(H_MAX_POS), .V_MAX_POS(V_MAX_POS), .MAX_VAL(MAX_VAL)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Index of the first occurrence of the largest sample among steps 0..n-1.
  function automatic int peak_pos(input int n);
    int p;
    p = 0;
    for (int k = 1; k < n; k++) if (samp[k] > samp[p]) p = k;
    return p;
  endfunction

  task automatic cnt_rst_pulse();
    CNT_RST = 1'b1;
    step();
    CNT_RST = 1'b0;
  endtask

  // The next clock edge starts the phase; a tick lands every STEP_DIV edges
  // after it, and step k's sample is supplied just after tick k.
  task automatic run_phase(input bit v, input int n, input int cycles, input bit chk_clr);
    for (int c = 0; c < cycles; c++) begin
      step();
      CNT_RST   = 1'b0;
      ADC_VALID = 1'b0;
      if ((c % STEP_DIV == 0) && (c / STEP_DIV < n)) begin
        ADC_VAL   = ADC_W'(samp[c / STEP_DIV]);
        ADC_VALID = 1'b1;
      end
      if (v) chk("cnt_d", CNT_D, (c / STEP_DIV) < n);
      else   chk("cnt_l", CNT_L, (c / STEP_DIV) < n);
      if (chk_clr && c == 0) begin
        chk("clr_pos", v ? V_MAX_POS : H_MAX_POS, 0);
        chk("clr_val", MAX_VAL, 0);
      end
    end
  endtask

  // Caller has just raised MC; expect CNT_RU high for exactly r steps.
  task automatic do_return(input int r);
    chk("ru_start", CNT_RU, r != 0);
    for (int c = 0; c < r * STEP_DIV + STEP_DIV; c++) begin
      step();
      chk("cnt_ru", CNT_RU, (c / STEP_DIV) < r);
    end
    MC = 1'b0;
  endtask

  task automatic full_sweep(input bit v);
    int n;
    int p;
    n = v ? V_STEPS : H_STEPS;
    p = peak_pos(n);
    if (v) VS = 1'b1;
    else   HS = 1'b1;
    run_phase(v, n, n * STEP_DIV + 1, 1'b0);
    step();
    if (v) begin
      chk("cnt_d_sat", CNT_D, 0);
      chk("v_max_pos", V_MAX_POS, p);
    end else begin
      chk("cnt_l_sat", CNT_L, 0);
      chk("h_max_pos", H_MAX_POS, p);
      h_keep = p;
    end
    chk("max_val", MAX_VAL, samp[p]);
    HS = 1'b0;
    VS = 1'b0;
    MC = 1'b1;
    do_return(n - p);
  endtask

  initial begin
    RST = 1'b1; HS = 1'b0; VS = 1'b0; MC = 1'b0; CNT_RST = 1'b0;
    ADC_VAL = '0; ADC_VALID = 1'b0;
    h_keep = 0;
    step();
    step();
    chk("rst_cnt_l", CNT_L, 1);
    chk("rst_cnt_d", CNT_D, 1);
    chk("rst_cnt_ru", CNT_RU, 0);
    chk("rst_h_pos", H_MAX_POS, 0);
    chk("rst_v_pos", V_MAX_POS, 0);
    chk("rst_max_val", MAX_VAL, 0);
    RST = 1'b0;
    step();

    // Horizontal peak at step 5
    cnt_rst_pulse();
    for (int k = 0; k < H_STEPS; k++) samp[k] = k * 10;
    samp[5] = 200;
    full_sweep(1'b0);

    // Vertical phase after the horizontal return, peak at step 2
    samp[0] = 5; samp[1] = 9; samp[2] = 40; samp[3] = 12;
    full_sweep(1'b1);
    chk("h_pos_kept", H_MAX_POS, h_keep);

    // Constant samples: earliest step wins
    cnt_rst_pulse();
    for (int k = 0; k < H_STEPS; k++) samp[k] = 50;
    full_sweep(1'b0);

    // Peak only at the last step
    cnt_rst_pulse();
    for (int k = 0; k < H_STEPS; k++) samp[k] = 10;
    samp[7] = 100;
    full_sweep(1'b0);

    // Abort at h_cnt = 3, then a fresh sweep with HS held high
    cnt_rst_pulse();
    for (int k = 0; k < H_STEPS; k++) samp[k] = k * 3;
    samp[2] = 999;
    HS = 1'b1;
    run_phase(1'b0, H_STEPS, 3 * STEP_DIV + 1, 1'b0);
    chk("abort_pre_pos", H_MAX_POS, 2);
    chk("abort_pre_val", MAX_VAL, 999);
    for (int k = 0; k < H_STEPS; k++) samp[k] = int'($urandom_range(0, 4095));
    CNT_RST = 1'b1;
    run_phase(1'b0, H_STEPS, H_STEPS * STEP_DIV + 1, 1'b1);
    step();
    chk("abort_pos", H_MAX_POS, peak_pos(H_STEPS));
    chk("abort_val", MAX_VAL, samp[peak_pos(H_STEPS)]);
    HS = 1'b0;
    step();

    // Randomized sweeps; narrow horizontal range makes ties likely
    for (int it = 0; it < 3; it++) begin
      cnt_rst_pulse();
      for (int k = 0; k < H_STEPS; k++) samp[k] = int'($urandom_range(0, 7));
      full_sweep(1'b0);
      for (int k = 0; k < V_STEPS; k++) samp[k] = int'($urandom_range(0, 4095));
      full_sweep(1'b1);
      chk("rand_h_kept", H_MAX_POS, h_keep);
    end

    // HS and VS together: only the horizontal counter runs
    cnt_rst_pulse();
    for (int k = 0; k < H_STEPS; k++) samp[k] = 20;
    samp[6] = 300;
    HS = 1'b1;
    VS = 1'b1;
    run_phase(1'b0, H_STEPS, H_STEPS * STEP_DIV + 1, 1'b0);
    step();
    chk("prio_cnt_l", CNT_L, 0);
    chk("prio_cnt_d", CNT_D, 1);
    chk("prio_h_pos", H_MAX_POS, 6);
    chk("prio_v_pos", V_MAX_POS, 0);
    HS = 1'b0;
    VS = 1'b0;
    MC = 1'b1;
    chk("prio_ru", CNT_RU, 1);
    repeat (STEP_DIV) step();
    chk("prio_ru_mid", CNT_RU, 1);
    RST = 1'b1;
    step();
    chk("rst_ret_ru", CNT_RU, 0);
    chk("rst_ret_cnt_l", CNT_L, 1);
    chk("rst_ret_h_pos", H_MAX_POS, 0);
    RST = 1'b0;
    MC = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
